fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory request, held high until imem_ack.
REQ-005 imem_addr  output  64  fetch address, stable while imem_req=1 and no imem_ack.
REQ-006 imem_ack  input  1  one-cycle pulse: imem_rdata is valid for the current request.
REQ-007 imem_rdata  input  32  instruction word returned with imem_ack.
REQ-008 id_stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-009 pc_src  input  1  branch taken; redirect fetch to pc_branch.
REQ-010 pc_branch  input  64  redirect target; bits [1:0] SHALL be treated as 00.
REQ-011 valid_id  output  1  IF/ID register holds a live instruction.
REQ-012 instr_id  output  32  IF/ID instruction word.
REQ-013 pc_id  output  64  address of instr_id.
REQ-014 op_id  output  11  instr_id[31:21], the opcode field for the main decoder.

Function
REQ-015 States SHALL be FETCH, HOLD and KILL.
- FETCH: request pc.
- HOLD: skid entry full, no request.
- KILL: draining a request that redirect made stale.
REQ-016 FETCH SHALL drive imem_req=1 and imem_addr=pc.
REQ-017 FETCH with imem_ack and (!id_stall or !valid_id) SHALL load the IF/ID register with {1, imem_rdata, pc} and set pc<=pc+4, all on the same edge.
REQ-018 FETCH with imem_ack, id_stall=1 and valid_id=1 SHALL capture {imem_rdata, pc} into the skid entry, set pc<=pc+4 and go to HOLD.
REQ-019 HOLD SHALL drive imem_req=0. When id_stall=0, the skid entry SHALL move into IF/ID with valid_id=1 and the state SHALL return to FETCH.
REQ-020 id_stall=1 with valid_id=1 SHALL hold instr_id, pc_id and valid_id unchanged.
REQ-021 id_stall=0 in FETCH without imem_ack SHALL clear valid_id to 0 and instr_id to 0 (bubble).
REQ-022 pc_src=1 SHALL take priority over id_stall and imem_ack. On the next edge: valid_id=0, instr_id=0, pc_id=0, skid cleared, pc<=pc_branch & ~64'h3.
REQ-023 pc_src=1 in FETCH while imem_req is high without imem_ack SHALL go to KILL.
- KILL holds imem_req=1 and the stale address (kill_addr register) until imem_ack.
- The returned data SHALL be discarded, then the state goes to FETCH at the new pc.
REQ-024 pc_src=1 in FETCH coincident with imem_ack SHALL discard imem_rdata and stay in FETCH at the target.
REQ-025 pc_src=1 in HOLD SHALL discard the skid entry and go to FETCH at the target.
REQ-026 pc_src=1 in KILL SHALL overwrite the pending target and remain in KILL.
REQ-027 pc+4 SHALL wrap modulo 2^64, with no overflow flag.
REQ-028 op_id SHALL be combinational from instr_id. A bubble yields 11'b0, which the decoder treats as its default (no-write) case.
REQ-029 Fetch latency SHALL be 1 cycle from imem_ack to valid_id when decode is not stalled. Zero-wait memory SHALL sustain one instruction per cycle.

Reset
REQ-030 While reset=0 the block SHALL hold these values:
- pc=RESET_PC, state=FETCH, imem_req=0.
- valid_id=0, instr_id=0, pc_id=0.
- skid entry empty.
REQ-031 imem_req SHALL first assert in the first cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-032 Reset mid-request SHALL abandon the outstanding request; any imem_ack in the first post-reset cycle SHALL be accepted as the response to RESET_PC.

Structure
REQ-033 Package fetch_pkg SHALL hold:
- the state enum (FETCH, HOLD, KILL);
- INSTR_W=32, ADDR_W=64, PC_STEP=4;
- the opcode field bounds 31:21.
REQ-034 The IF/ID register with flush/stall/load controls SHALL be a sub-module named if_id_reg. The FSM, pc and skid SHALL stay in fetch_stage.

Verification
REQ-035 Zero-wait memory returns 32'hF84003E1 @0, 32'h8B020020 @4:
- valid_id high from cycle 2;
- pc_id 0 then 4;
- op_id 11'h7C2 then 11'h458.
REQ-036 id_stall=1 for 3 cycles while valid_id=1 and an ack arrives:
- the state enters HOLD and imem_req=0;
- instr_id is unchanged for 3 cycles;
- after release, the skid word appears with pc_id = old pc_id+4.
REQ-037 Redirect during an outstanding request: pc_src=1, pc_branch=64'h103 at pc=8, no ack, ack arrives 2 cycles later:
- KILL holds imem_addr=8;
- the data is discarded;
- the next imem_addr=64'h100;
- valid_id=0 until the 64'h100 response.
REQ-038 Simultaneous pc_src=1, id_stall=1 and imem_ack:
- the next cycle shows valid_id=0 and op_id=0;
- pc=pc_branch;
- state FETCH.
REQ-039 pc=64'hFFFF_FFFF_FFFF_FFFC fetch acknowledged -> next imem_addr=64'h0.
REQ-040 reset asserted while in KILL:
- imem_req=0 and valid_id=0 immediately;
- after release, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } state_t;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int PC_STEP = 4;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 21;
  localparam int OP_W    = OP_HI - OP_LO + 1;

  // Instructions are word aligned: force the two low address bits to zero.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Purpose: IF/ID pipeline register with flush, load and bubble controls.
// Latency: 1 cycle from control/data inputs to outputs.
// Backpressure: with no control asserted the contents hold (decode stall).
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // Flush wins over load; bubble clears valid and the word but keeps pc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= '0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch FSM (FETCH/HOLD/KILL), pc, one-entry skid and IF/ID.
// Latency: 1 cycle from imem_ack to valid_id; one instruction per cycle at zero wait.
// Backpressure: id_stall holds IF/ID; one extra word parks in the skid and stops requests.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  pc_branch,
  output logic               valid_id,
  output logic [INSTR_W-1:0] instr_id,
  output logic [ADDR_W-1:0]  pc_id,
  output logic [OP_W-1:0]    op_id
);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  kill_addr, kill_addr_nxt;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;
  logic               skid_we;
  logic               flush, load, bubble;
  logic [INSTR_W-1:0] ld_instr;
  logic [ADDR_W-1:0]  ld_pc;

  // Request is live in FETCH and KILL; reset forces it low immediately.
  assign imem_req  = reset && (state != HOLD);
  assign imem_addr = (state == KILL) ? kill_addr : pc;
  assign op_id     = instr_id[OP_HI:OP_LO];

  // State, pc, stale-request address and skid entry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      kill_addr  <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      kill_addr <= kill_addr_nxt;
      if (skid_we) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
      end else if (flush) begin
        skid_instr <= '0;
        skid_pc    <= '0;
      end
    end
  end

  // Next state, next pc and IF/ID controls; redirect beats stall and ack.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    kill_addr_nxt = kill_addr;
    skid_we       = 1'b0;
    flush         = 1'b0;
    load          = 1'b0;
    bubble        = 1'b0;
    ld_instr      = imem_rdata;
    ld_pc         = pc;
    case (state)
      FETCH: begin
        if (pc_src) begin
          flush  = 1'b1;
          pc_nxt = align_pc(pc_branch);
          // A request still in flight must be drained before refetching.
          if (!imem_ack) begin
            state_nxt     = KILL;
            kill_addr_nxt = pc;
          end
        end else if (imem_ack) begin
          pc_nxt = pc + ADDR_W'(PC_STEP);
          if (id_stall && valid_id) begin
            skid_we   = 1'b1;
            state_nxt = HOLD;
          end else begin
            load = 1'b1;
          end
        end else if (!id_stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (pc_src) begin
          flush     = 1'b1;
          pc_nxt    = align_pc(pc_branch);
          state_nxt = FETCH;
        end else if (!id_stall) begin
          load      = 1'b1;
          ld_instr  = skid_instr;
          ld_pc     = skid_pc;
          state_nxt = FETCH;
        end
      end
      KILL: begin
        if (pc_src) begin
          flush  = 1'b1;
          pc_nxt = align_pc(pc_branch);
        end
        // The ack retires the stale request; a same-cycle redirect only
        // updates the target, so no second stale fetch is issued.
        if (imem_ack) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (load),
    .bubble     (bubble),
    .load_instr (ld_instr),
    .load_pc    (ld_pc),
    .valid      (valid_id),
    .instr      (instr_id),
    .pc         (pc_id)
  );

endmodule
